// File: rtl/controle_chamada_pkg.sv
// Shared definitions for the call/return sequencer: default widths, full-stack constant, FSM encoding.
// Optional feature macro used across this slice: PILHA_MARCA_EN (high-water depth output).
package controle_chamada_pkg;

   localparam int LARGURA_PADRAO      = 11;
   localparam int PROFUNDIDADE_PADRAO = 7;
   localparam int PILHA_CHEIA         = 2 ** PROFUNDIDADE_PADRAO;

   localparam logic [0:0] EXEC       = 1'b0;
   localparam logic [0:0] RET_ESPERA = 1'b1;

endpackage

// File: rtl/controle_chamada_profundidade.sv
// Saturating up/down counter tracking return-stack depth, with full/empty flags.
// With PILHA_MARCA_EN defined it also keeps the high-water depth since reset.
module contador_profundidade
   import controle_chamada_pkg::*;
#(
   parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  incrementa,
   input  logic                  decrementa,
   output logic                  cheio,
   output logic                  vazio
`ifdef PILHA_MARCA_EN
   ,
   output logic [PROFUNDIDADE:0] marca_max
`endif
);

   localparam logic [PROFUNDIDADE:0] MAXIMO = {1'b1, {PROFUNDIDADE{1'b0}}};

   logic [PROFUNDIDADE:0] profundidade_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         profundidade_reg <= '0;
      end else if (incrementa && !decrementa && !cheio) begin
         profundidade_reg <= profundidade_reg + 1'b1;
      end else if (decrementa && !incrementa && !vazio) begin
         profundidade_reg <= profundidade_reg - 1'b1;
      end
   end

   assign cheio = (profundidade_reg == MAXIMO);
   assign vazio = (profundidade_reg == '0);

`ifdef PILHA_MARCA_EN
   logic [PROFUNDIDADE:0] marca_reg;

   // Depth only grows by one per push, so a new maximum is reached exactly when depth equals the mark.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         marca_reg <= '0;
      end else if (incrementa && !decrementa && !cheio && (profundidade_reg == marca_reg)) begin
         marca_reg <= profundidade_reg + 1'b1;
      end
   end

   assign marca_max = marca_reg;
`endif

endmodule

// File: rtl/controle_chamada.sv
// Program-counter sequencer and sole master of the return-address stack (push/pop/data side).
// Define PILHA_MARCA_EN to expose marca_max, the high-water stack depth since reset.
module controle_chamada
   import controle_chamada_pkg::*;
#(
   parameter int                 LARGURA      = LARGURA_PADRAO,
   parameter int                 PROFUNDIDADE = PROFUNDIDADE_PADRAO,
   parameter logic [LARGURA-1:0] PC_INICIAL   = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  avanca,
   input  logic                  salto,
   input  logic                  chamada,
   input  logic                  retorno,
   input  logic [LARGURA-1:0]    alvo,
   output logic [LARGURA-1:0]    pc,
   output logic                  ocupado,
   output logic                  erro_over,
   output logic                  erro_under,
   output logic [LARGURA-1:0]    pilha_dado,
   output logic                  pilha_push,
   output logic                  pilha_pop,
   input  logic [LARGURA-1:0]    pilha_topo
`ifdef PILHA_MARCA_EN
   ,
   output logic [PROFUNDIDADE:0] marca_max
`endif
);

   logic [LARGURA-1:0] pc_reg, pc_next, pc_mais_um;
   logic [0:0]         state_reg, state_next;
   logic               erro_over_reg, erro_over_next;
   logic               erro_under_reg, erro_under_next;
   logic               cheio, vazio;
   logic               em_exec, faz_push, faz_pop;

   contador_profundidade #(
      .PROFUNDIDADE (PROFUNDIDADE)
   ) u_contador (
      .clk        (clk),
      .reset      (reset),
      .incrementa (faz_push),
      .decrementa (faz_pop),
      .cheio      (cheio),
      .vazio      (vazio)
`ifdef PILHA_MARCA_EN
      ,
      .marca_max  (marca_max)
`endif
   );

   // Strobes are combinational from inputs, so they are also masked while reset is held.
   assign pc_mais_um = pc_reg + 1'b1;
   assign em_exec    = reset && (state_reg == EXEC);
   assign faz_pop    = em_exec && retorno && !vazio;
   assign faz_push   = em_exec && !retorno && chamada && !cheio;

   always_comb begin
      pc_next         = pc_reg;
      state_next      = state_reg;
      erro_over_next  = erro_over_reg;
      erro_under_next = erro_under_reg;
      if (state_reg == RET_ESPERA) begin
         pc_next    = pilha_topo;
         state_next = EXEC;
      end else if (retorno) begin
         if (!vazio) begin
            state_next = RET_ESPERA;
         end else begin
            erro_under_next = 1'b1;
            pc_next         = pc_mais_um;
         end
      end else if (chamada) begin
         if (!cheio) begin
            pc_next = alvo;
         end else begin
            erro_over_next = 1'b1;
            pc_next        = pc_mais_um;
         end
      end else if (salto) begin
         pc_next = alvo;
      end else if (avanca) begin
         pc_next = pc_mais_um;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_reg         <= PC_INICIAL;
         state_reg      <= EXEC;
         erro_over_reg  <= 1'b0;
         erro_under_reg <= 1'b0;
      end else begin
         pc_reg         <= pc_next;
         state_reg      <= state_next;
         erro_over_reg  <= erro_over_next;
         erro_under_reg <= erro_under_next;
      end
   end

   assign pc         = pc_reg;
   assign ocupado    = (state_reg == RET_ESPERA);
   assign erro_over  = erro_over_reg;
   assign erro_under = erro_under_reg;
   assign pilha_push = faz_push;
   assign pilha_pop  = faz_pop;
   assign pilha_dado = faz_push ? pc_mais_um : '0;

endmodule

// File: tb/tb_controle_chamada.sv
// Self-checking bench for controle_chamada: reference model feeds a scoreboard queue, checked each cycle.
// Honours PILHA_MARCA_EN when defined (checks marca_max too).
module tb_controle_chamada;

   localparam int N = 128;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        avanca = 1'b0, salto = 1'b0, chamada = 1'b0, retorno = 1'b0;
   logic [10:0] alvo = '0;
   logic [10:0] pc, pilha_dado, pilha_topo;
   logic        ocupado, erro_over, erro_under, pilha_push, pilha_pop;
`ifdef PILHA_MARCA_EN
   logic [7:0]  marca_max;
`endif

   controle_chamada dut (
      .clk        (clk),
      .reset      (reset),
      .avanca     (avanca),
      .salto      (salto),
      .chamada    (chamada),
      .retorno    (retorno),
      .alvo       (alvo),
      .pc         (pc),
      .ocupado    (ocupado),
      .erro_over  (erro_over),
      .erro_under (erro_under),
      .pilha_dado (pilha_dado),
      .pilha_push (pilha_push),
      .pilha_pop  (pilha_pop),
      .pilha_topo (pilha_topo)
`ifdef PILHA_MARCA_EN
      ,
      .marca_max  (marca_max)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural return-address stack driven by the DUT strobes.
   logic [10:0] mem [0:255];
   logic [8:0]  sp;
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         sp         <= '0;
         pilha_topo <= '0;
      end else if (pilha_push) begin
         mem[sp[7:0]] <= pilha_dado;
         sp           <= sp + 9'd1;
      end else if (pilha_pop) begin
         pilha_topo <= mem[sp[7:0] - 8'd1];
         sp         <= sp - 9'd1;
      end
   end

   typedef struct packed {
      logic [10:0] pc;
      logic        push;
      logic        pop;
      logic [10:0] dado;
      logic        ocup;
      logic        eo;
      logic        eu;
      logic [7:0]  marca;
   } esperado_t;

   esperado_t fila[$];
   int comparados = 0;
   int divergentes = 0;
   int n_passo = 0;

   // Reference model state
   logic [10:0] m_pc;
   logic [10:0] m_stack [0:N-1];
   int          m_depth, m_marca;
   logic        m_ret, m_eo, m_eu;

   task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      comparados++;
      if (obs !== esp) begin
         divergentes++;
         $display("FAIL %s: obtido=%h esperado=%h", tag, obs, esp);
      end
   endtask

   task automatic modelo_reset();
      m_pc = '0; m_depth = 0; m_marca = 0; m_ret = 1'b0; m_eo = 1'b0; m_eu = 1'b0;
      fila.delete();
   endtask

   task automatic checa_saida();
      esperado_t e;
      if (fila.size() == 0) begin
         confere("fila_vazia", 32'd0, 32'd1);
      end else begin
         e = fila.pop_front();
         confere("pc", pc, e.pc);
         confere("push", pilha_push, e.push);
         confere("pop", pilha_pop, e.pop);
         confere("dado", pilha_dado, e.dado);
         confere("ocupado", ocupado, e.ocup);
         confere("erro_over", erro_over, e.eo);
         confere("erro_under", erro_under, e.eu);
`ifdef PILHA_MARCA_EN
         confere("marca_max", marca_max, e.marca);
`endif
      end
   endtask

   task automatic passo(input logic av, input logic sa, input logic ch, input logic re,
                        input logic [10:0] al);
      esperado_t e;
      @(negedge clk);
      avanca = av; salto = sa; chamada = ch; retorno = re; alvo = al;
      e.pc    = m_pc;
      e.push  = !m_ret && !re && ch && (m_depth < N);
      e.pop   = !m_ret && re && (m_depth > 0);
      e.dado  = e.push ? (m_pc + 11'd1) : 11'd0;
      e.ocup  = m_ret;
      e.eo    = m_eo;
      e.eu    = m_eu;
      e.marca = m_marca[7:0];
      fila.push_back(e);
      if (m_ret) begin
         m_pc  = m_stack[m_depth];
         m_ret = 1'b0;
      end else if (re) begin
         if (m_depth > 0) begin
            m_depth--;
            m_ret = 1'b1;
         end else begin
            m_eu = 1'b1;
            m_pc = m_pc + 11'd1;
         end
      end else if (ch) begin
         if (m_depth < N) begin
            m_stack[m_depth] = m_pc + 11'd1;
            m_depth++;
            m_pc = al;
            if (m_depth > m_marca) m_marca = m_depth;
         end else begin
            m_eo = 1'b1;
            m_pc = m_pc + 11'd1;
         end
      end else if (sa) begin
         m_pc = al;
      end else if (av) begin
         m_pc = m_pc + 11'd1;
      end
      #1;
      checa_saida();
      n_passo++;
      $display("passo %0d: av=%b sa=%b ch=%b re=%b alvo=%h | pc=%h push=%b pop=%b dado=%h ocup=%b eo=%b eu=%b",
               n_passo, av, sa, ch, re, al, pc, pilha_push, pilha_pop, pilha_dado, ocupado,
               erro_over, erro_under);
   endtask

   task automatic aplica_reset(input int ciclos);
      @(negedge clk);
      reset = 1'b0;
      modelo_reset();
      for (int i = 0; i < ciclos; i++) begin
         @(negedge clk);
         {avanca, salto, chamada, retorno} = 4'($urandom_range(1, 15));
         alvo = 11'($urandom);
         #1;
         confere("rst_pc", pc, 32'd0);
         confere("rst_push", pilha_push, 32'd0);
         confere("rst_pop", pilha_pop, 32'd0);
         confere("rst_dado", pilha_dado, 32'd0);
         confere("rst_ocupado", ocupado, 32'd0);
         confere("rst_erros", {erro_over, erro_under}, 32'd0);
      end
      @(negedge clk);
      {avanca, salto, chamada, retorno} = 4'b0000;
      reset = 1'b1;
      $display("reset liberado");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulacao nao terminou, limite=%0d ns", 200000);
      $fatal(1);
   end

   initial begin
      // 1: reset, then three advances
      aplica_reset(4);
      passo(1, 0, 0, 0, 11'h000);
      passo(1, 0, 0, 0, 11'h000);
      passo(1, 0, 0, 0, 11'h000);
      passo(0, 0, 0, 0, 11'h000);
      confere("pc_apos_3", pc, 32'h003);

      // 2: single call/return
      passo(0, 1, 0, 0, 11'h010);
      passo(0, 0, 1, 0, 11'h200);
      passo(0, 0, 0, 1, 11'h000);
      passo(0, 0, 0, 0, 11'h000);
      passo(0, 0, 0, 0, 11'h000);
      confere("ret_pc", pc, 32'h011);

      // 3: three nested calls and returns
      passo(0, 0, 1, 0, 11'h100);
      passo(0, 0, 1, 0, 11'h200);
      passo(0, 0, 1, 0, 11'h300);
      for (int i = 0; i < 3; i++) begin
         passo(0, 0, 0, 1, 11'h000);
         passo(0, 0, 0, 0, 11'h000);
      end
      passo(0, 0, 0, 0, 11'h000);
      confere("aninhado_pc", pc, 32'h012);

      // 4: underflow at depth 0
      passo(0, 1, 0, 0, 11'h005);
      passo(0, 0, 0, 1, 11'h000);
      passo(0, 0, 0, 0, 11'h000);
      confere("under_pc", pc, 32'h006);
      confere("under_flag", erro_under, 32'd1);

      // 5: fill the stack, then overflow
      aplica_reset(2);
      for (int i = 0; i < N; i++) passo(0, 0, 1, 0, 11'(i));
      passo(0, 0, 1, 0, 11'h7AA);
      passo(0, 0, 0, 0, 11'h000);
      confere("over_pc", pc, 32'h080);
      confere("over_flag", erro_over, 32'd1);
`ifdef PILHA_MARCA_EN
      confere("marca_128", marca_max, 32'd128);
`endif

      // 6: priority, busy window, wrap-around
      aplica_reset(2);
      passo(0, 0, 1, 0, 11'h050);
      passo(1, 1, 1, 1, 11'h333);
      passo(1, 1, 1, 1, 11'h444);
      passo(0, 0, 0, 0, 11'h000);
      confere("prio_pc", pc, 32'h001);
      passo(0, 1, 0, 0, 11'h7FF);
      passo(1, 0, 0, 0, 11'h000);
      passo(0, 0, 0, 0, 11'h000);
      confere("wrap_pc", pc, 32'h000);
      passo(0, 1, 0, 0, 11'h7FF);
      passo(0, 0, 1, 0, 11'h010);
      passo(0, 0, 0, 1, 11'h000);
      passo(0, 0, 0, 0, 11'h000);
      passo(0, 0, 0, 0, 11'h000);
      confere("wrap_ret_pc", pc, 32'h000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparados, divergentes);
      $finish;
   end

endmodule
